frame_capture_sequencer: RTL
============================

FRAME_CAPTURE_SEQUENCER -- requirements
Module: frame_capture_sequencer

Interface
REQ-001 Parameter: TIMEOUT_W, default 24, width of the timeout counter and of timeout_cycles_i.
REQ-002 Port: clk_i  in  1  single clock; also the frame_sync_generator out_clk_i domain.
REQ-003 Port: reset_i  in  1  reset, asynchronous, active-high.
REQ-004 Port: frame_sync_i  in  1  level from frame_sync_generator; 1 = inter-frame blanking (clock lane LP), 0 = frame active.
REQ-005 Port: line_valid_i  in  1  pixel-pipeline line valid; each rising edge counts as one line.
REQ-006 Port: start_i / stop_i  in  1 each  host command pulses, one cycle.
REQ-007 Port: single_shot_i  in  1  1 = capture one frame then return to IDLE.
REQ-008 Port: frame_skip_i  in  4  capture one frame, then skip N frames.
REQ-009 Port: sink_ready_i  in  1  downstream USB FIFO can accept a whole frame.
REQ-010 Port: timeout_cycles_i  in  TIMEOUT_W  watchdog limit; 0 = watchdog disabled.
REQ-011 Port: capture_en_o  out  1  gate to the pixel pipeline.
REQ-012 Port: frame_start_o / frame_end_o  out  1 each  one-cycle pulses.
REQ-013 Port: frame_count_o  out  16  frames completed; wraps at 0xFFFF.
REQ-014 Port: lines_o  out  16  line count of the last completed frame.
REQ-015 Port: dropped_count_o  out  16  frames dropped because sink_ready_i=0; saturates at 0xFFFF.
REQ-016 Port: busy_o  out  1  1 in any state other than IDLE.
REQ-017 Port: timeout_o  out  1  sticky watchdog flag.

Function
REQ-018 frame_sync_i shall be registered (fs_q); frame-start edge = fs_q=1 & frame_sync_i=0; frame-end edge = fs_q=0 & frame_sync_i=1.
REQ-019 States: IDLE, ARM, CAPTURE, SKIP; all outputs registered.
REQ-020 IDLE: start_i -> ARM and clears skip_cnt and timeout_o; start_i is ignored outside IDLE.
REQ-021 ARM: waits for a frame-start edge only; a frame already active at arming is never captured.
REQ-022 ARM, on frame-start edge with skip_cnt=0 and sink_ready_i=1 -> CAPTURE; frame_start_o and capture_en_o rise one cycle after the edge cycle.
REQ-023 ARM, on frame-start edge with skip_cnt!=0 -> SKIP and skip_cnt decrements.
REQ-024 ARM, on frame-start edge with skip_cnt=0 and sink_ready_i=0 -> SKIP and dropped_count_o increments.
REQ-025 SKIP: on frame-end edge -> ARM.
REQ-026 CAPTURE: capture_en_o=1; the line counter starts at 0 and increments on each line_valid_i rising edge, saturating at 0xFFFF.
REQ-027 CAPTURE, on frame-end edge: the next cycle gives frame_end_o=1, capture_en_o=0, frame_count_o+1, lines_o=line counter, skip_cnt=frame_skip_i.
REQ-028 After CAPTURE ends: -> IDLE if single_shot_i=1 or a stop is pending, else -> ARM.
REQ-029 stop_i in ARM/SKIP -> IDLE next cycle; in CAPTURE it sets stop-pending and the frame completes normally.
REQ-030 start_i and stop_i in the same IDLE cycle: stop wins, stay IDLE.
REQ-031 Watchdog: counter runs in ARM/SKIP/CAPTURE, clears on any frame_sync edge and on state entry.
REQ-032 When the watchdog counter reaches a nonzero timeout_cycles_i: timeout_o=1 and -> IDLE; from CAPTURE also frame_end_o pulses, with frame_count_o and lines_o unchanged.
REQ-033 sink_ready_i is sampled only at frame start; deassertion during CAPTURE does not abort the frame.

Reset
REQ-034 reset_i shall force state IDLE, fs_q=1, and every counter, flag and output to 0, independent of clk_i.
REQ-035 Reset mid-CAPTURE shall drop capture_en_o immediately with no frame_end_o; after release the sequencer waits in IDLE for start_i.

Structure
REQ-036 Package frame_seq_pkg holds the state enum, the 16-bit counter width and the skip width (4).
REQ-037 One sub-module, fs_edge_detect (register plus rise/fall pulses), shall be reused for frame_sync_i and line_valid_i.

Verification
REQ-038 start_i while frame_sync_i=0 mid-frame -> no capture that frame; next 1->0 edge -> frame_start_o one cycle later; 5 line pulses, then 0->1 -> frame_end_o, lines_o=5, frame_count_o=1.
REQ-039 frame_skip_i=2 over 6 frames -> frames 1 and 4 captured, frame_count_o=2.
REQ-040 sink_ready_i=0 at 3 frame starts -> dropped_count_o=3, capture_en_o stays 0.
REQ-041 stop_i mid-CAPTURE -> frame completes with frame_end_o, then IDLE with busy_o=0; start_i+stop_i together in IDLE -> stays IDLE.
REQ-042 timeout_cycles_i=100, frame_sync_i held 0 in CAPTURE -> frame_end_o and timeout_o=1 after 100 cycles, IDLE, frame_count_o unchanged; next start_i clears timeout_o.
REQ-043 reset_i asserted mid-CAPTURE, asynchronously to clk_i -> capture_en_o=0 at once, all counters 0, no frame_end_o.

Source files
------------

// File: rtl/frame_seq_pkg.sv
// Shared types for the frame capture sequencer.
// State encoding, counter widths and a saturating increment.
package frame_seq_pkg;

  localparam int CNT_W  = 16;
  localparam int SKIP_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_SKIP
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fs_edge_detect.sv
// Registers a level and flags its rising/falling edges.
// Ports: clk_i, reset_i, sig_i -> rise_o, fall_o (combinational pulses).
module fs_edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;
  logic sig_d;

  assign sig_d = sig_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) sig_q <= RESET_VAL;
    else         sig_q <= sig_d;
  end

  assign rise_o = ~sig_q & sig_i;
  assign fall_o = sig_q & ~sig_i;

endmodule

// File: rtl/frame_capture_sequencer.sv
// Arms on host start, captures whole frames, skips/drops, watchdog.
// In: frame_sync/line_valid/start/stop/cfg; out: gate, pulses, counters.
module frame_capture_sequencer
  import frame_seq_pkg::*;
#(
  parameter int TIMEOUT_W = 24
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 frame_sync_i,
  input  logic                 line_valid_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 single_shot_i,
  input  logic [SKIP_W-1:0]    frame_skip_i,
  input  logic                 sink_ready_i,
  input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
  output logic                 capture_en_o,
  output logic                 frame_start_o,
  output logic                 frame_end_o,
  output logic [CNT_W-1:0]     frame_count_o,
  output logic [CNT_W-1:0]     lines_o,
  output logic [CNT_W-1:0]     dropped_count_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  state_e               state_q, state_d;
  logic [SKIP_W-1:0]    skip_q, skip_d;
  logic                 stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0]     line_q, line_d, line_nxt;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]     lines_q, lines_d;
  logic [CNT_W-1:0]     drop_q, drop_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
  logic                 timeout_q, timeout_d;
  logic                 fstart_q, fstart_d;
  logic                 fend_q, fend_d;
  logic                 cap_q, cap_d;
  logic                 busy_q, busy_d;
  logic                 fs_rise, fs_fall;
  logic                 lv_rise, lv_fall_unused;
  logic                 wd_fire;

  // Frame sync idles in blanking, so its register resets to 1.
  fs_edge_detect #(.RESET_VAL(1'b1)) u_fs_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sig_i   (frame_sync_i),
    .rise_o  (fs_rise),
    .fall_o  (fs_fall)
  );

  fs_edge_detect #(.RESET_VAL(1'b0)) u_lv_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sig_i   (line_valid_i),
    .rise_o  (lv_rise),
    .fall_o  (lv_fall_unused)
  );

  assign wd_inc   = wd_q + TIMEOUT_W'(1);
  assign line_nxt = lv_rise ? sat_inc(line_q) : line_q;

  // Fires on the cycle the quiet-cycle count reaches the limit.
  assign wd_fire = (state_q != S_IDLE)
                 & ~(fs_rise | fs_fall)
                 & (timeout_cycles_i != '0)
                 & (wd_inc == timeout_cycles_i);

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    stop_pend_d = stop_pend_q;
    line_d      = line_q;
    frame_cnt_d = frame_cnt_q;
    lines_d     = lines_q;
    drop_d      = drop_q;
    timeout_d   = timeout_q;
    fstart_d    = 1'b0;
    fend_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          state_d     = S_ARM;
          skip_d      = '0;
          timeout_d   = 1'b0;
          stop_pend_d = 1'b0;
        end
      end
      S_ARM: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (wd_fire) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else if (fs_fall) begin
          if (skip_q != '0) begin
            state_d = S_SKIP;
            skip_d  = skip_q - SKIP_W'(1);
          end else if (sink_ready_i) begin
            state_d  = S_CAPTURE;
            fstart_d = 1'b1;
            line_d   = '0;
          end else begin
            state_d = S_SKIP;
            drop_d  = sat_inc(drop_q);
          end
        end
      end
      S_SKIP: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (wd_fire) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else if (fs_rise) begin
          state_d = S_ARM;
        end
      end
      S_CAPTURE: begin
        line_d = line_nxt;
        if (stop_i) stop_pend_d = 1'b1;
        if (fs_rise) begin
          fend_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          lines_d     = line_nxt;
          skip_d      = frame_skip_i;
          if (single_shot_i || stop_pend_q || stop_i)
            state_d = S_IDLE;
          else
            state_d = S_ARM;
        end else if (wd_fire) begin
          // Aborted frame: close it without counting it.
          fend_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
    endcase

    if (state_q == S_IDLE || state_d != state_q ||
        fs_rise || fs_fall)
      wd_d = '0;
    else
      wd_d = wd_inc;

    cap_d  = (state_d == S_CAPTURE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      skip_q      <= '0;
      stop_pend_q <= 1'b0;
      line_q      <= '0;
      frame_cnt_q <= '0;
      lines_q     <= '0;
      drop_q      <= '0;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
      fstart_q    <= 1'b0;
      fend_q      <= 1'b0;
      cap_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      stop_pend_q <= stop_pend_d;
      line_q      <= line_d;
      frame_cnt_q <= frame_cnt_d;
      lines_q     <= lines_d;
      drop_q      <= drop_d;
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
      fstart_q    <= fstart_d;
      fend_q      <= fend_d;
      cap_q       <= cap_d;
      busy_q      <= busy_d;
    end
  end

  assign capture_en_o    = cap_q;
  assign frame_start_o   = fstart_q;
  assign frame_end_o     = fend_q;
  assign frame_count_o   = frame_cnt_q;
  assign lines_o         = lines_q;
  assign dropped_count_o = drop_q;
  assign busy_o          = busy_q;
  assign timeout_o       = timeout_q;

endmodule
